// File: rtl/iram_arb_pkg.sv
// iRAM port arbiter shared definitions.
// State and owner encodings, default widths, iRAM depth.
package iram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 24;
    localparam int IRAM_DEPTH = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_READ_CAP,
        ST_RD_DONE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_WRITE = 2'd2,
        OWN_DEBUG = 2'd3
    } owner_e;

    // Round-robin memory: which class got the last grant.
    localparam logic GRANT_WR  = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

endpackage

// File: rtl/iram_port_arbiter_if.sv
// Requester, RAM-port and status bundle of the iRAM arbiter.
// slave = arbiter side, master = requesters / RAM side.
interface iram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic              cpu_paused;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              dbg_rd_req;
    logic [ADDR_W-1:0] dbg_rd_addr;
    logic [DATA_W-1:0] dbg_rd_data;
    logic              dbg_rd_valid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        owner;
    logic              wr_blocked;

    modport slave (
        input  cpu_paused, fetch_addr,
        input  wr_req, wr_addr, wr_data,
        input  dbg_rd_req, dbg_rd_addr,
        input  ram_rdata,
        output fetch_instr, fetch_valid,
        output wr_ack,
        output dbg_rd_data, dbg_rd_valid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output owner, wr_blocked
    );

    modport master (
        output cpu_paused, fetch_addr,
        output wr_req, wr_addr, wr_data,
        output dbg_rd_req, dbg_rd_addr,
        output ram_rdata,
        input  fetch_instr, fetch_valid,
        input  wr_ack,
        input  dbg_rd_data, dbg_rd_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  owner, wr_blocked
    );

endinterface

// File: rtl/iram_port_arbiter.sv
// Single iRAM port shared by CPU fetch, loader writes
// and debug reads; fetch owns it while the CPU runs.
module iram_port_arbiter
    import iram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    iram_port_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              fv_q, fv_d;
    logic              blk_q, blk_d;
    logic              wr_wins;

    // Next-state, arbitration and latch capture.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        fv_d      = (state_q == ST_RUN);
        blk_d     = blk_q;
        wr_wins   = bus.wr_req &
                    (~bus.dbg_rd_req | (last_q == GRANT_DBG));
        if (bus.wr_req &&
            ((state_q == ST_RUN) ||
             ((state_q == ST_IDLE) && !bus.cpu_paused)))
            blk_d = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                if (bus.cpu_paused)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.cpu_paused) begin
                    state_d = ST_RUN;
                end else if (wr_wins) begin
                    addr_d  = bus.wr_addr;
                    wdata_d = bus.wr_data;
                    last_d  = GRANT_WR;
                    state_d = ST_WRITE;
                end else if (bus.dbg_rd_req) begin
                    addr_d  = bus.dbg_rd_addr;
                    last_d  = GRANT_DBG;
                    state_d = ST_READ;
                end
            end
            ST_WRITE:    state_d = ST_HOLD;
            ST_READ:     state_d = ST_READ_CAP;
            ST_READ_CAP: begin
                rd_data_d = bus.ram_rdata;
                state_d   = ST_RD_DONE;
            end
            ST_RD_DONE:  state_d = ST_HOLD;
            ST_HOLD:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and latch registers; async reset lands in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= GRANT_DBG;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            fv_q      <= 1'b0;
            blk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            fv_q      <= fv_d;
            blk_q     <= blk_d;
        end
    end

    // Port and handshake outputs decoded from registered state.
    always_comb begin
        bus.ram_en       = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_wdata    = '0;
        bus.wr_ack       = 1'b0;
        bus.dbg_rd_valid = 1'b0;
        bus.owner        = OWN_NONE;
        unique case (state_q)
            ST_RUN: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = bus.fetch_addr;
                bus.owner    = OWN_FETCH;
            end
            ST_WRITE: begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = addr_q;
                bus.ram_wdata = wdata_q;
                bus.wr_ack    = 1'b1;
                bus.owner     = OWN_WRITE;
            end
            ST_READ: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = addr_q;
                bus.owner    = OWN_DEBUG;
            end
            ST_RD_DONE: bus.dbg_rd_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.fetch_instr = bus.ram_rdata;
    assign bus.fetch_valid = fv_q;
    assign bus.dbg_rd_data = rd_data_q;
    assign bus.wr_blocked  = blk_q;

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Self-checking bench for iram_port_arbiter.
// Includes a 256x24 synchronous RAM model on the port.
module tb_iram_port_arbiter;
    import iram_arb_pkg::*;

    logic clk;
    logic rst;

    iram_port_arbiter_if #(.ADDR_W(8), .DATA_W(24)) bus ();

    iram_port_arbiter #(.ADDR_W(8), .DATA_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [23:0] mem     [IRAM_DEPTH];
    logic [23:0] ref_mem [IRAM_DEPTH];
    logic [23:0] exp_q [$];
    logic [1:0]  grants [$];

    int checks;
    int errors;
    int we_cnt;
    int ack_cnt;
    int rv_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // RAM model: read-first synchronous port.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we)
                mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Monitors: pulse counters, grant log, read scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) we_cnt++;
            if (bus.wr_ack) ack_cnt++;
            if (bus.owner == 2'd2 || bus.owner == 2'd3)
                grants.push_back(bus.owner);
            if (bus.dbg_rd_valid) begin
                rv_cnt++;
                if (exp_q.size() == 0)
                    check("rd_extra", 1, 0);
                else
                    check("rd_data", bus.dbg_rd_data,
                          exp_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [7:0] a,
                            input logic [23:0] d);
        int n;
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_ack && n < 10);
        check("wr_lat", n - 1, 1);
        check("wr_addr", bus.ram_addr, a);
        check("wr_wdata", bus.ram_wdata, d);
        check("wr_we", bus.ram_we, 1);
        ref_mem[a] = d;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a);
        int n;
        exp_q.push_back(ref_mem[a]);
        bus.dbg_rd_req  = 1'b1;
        bus.dbg_rd_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dbg_rd_valid && n < 10);
        check("rd_lat", n - 1, 3);
        @(posedge clk); #1;
        bus.dbg_rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rv0;
        checks  = 0;
        errors  = 0;
        we_cnt  = 0;
        ack_cnt = 0;
        rv_cnt  = 0;
        for (int i = 0; i < IRAM_DEPTH; i++) begin
            mem[i]     = {8'hA5 ^ i[7:0], i[7:0], ~i[7:0]};
            ref_mem[i] = {8'hA5 ^ i[7:0], i[7:0], ~i[7:0]};
        end
        bus.ram_rdata   = '0;
        bus.cpu_paused  = 1'b0;
        bus.fetch_addr  = 8'h05;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.dbg_rd_req  = 1'b0;
        bus.dbg_rd_addr = '0;
        rst = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_owner", bus.owner, 0);
        check("rst_en", bus.ram_en, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        check("rst_fv", bus.fetch_valid, 0);
        check("rst_ack", bus.wr_ack, 0);
        check("rst_rv", bus.dbg_rd_valid, 0);
        check("rst_rdata", bus.dbg_rd_data, 0);
        check("rst_blk", bus.wr_blocked, 0);
        rst = 1'b0;

        // Fetch path.
        @(posedge clk); #1;
        check("run_owner", bus.owner, 1);
        check("run_en", bus.ram_en, 1);
        check("run_addr", bus.ram_addr, 8'h05);
        check("run_fv0", bus.fetch_valid, 0);
        @(posedge clk); #1;
        check("fetch_fv", bus.fetch_valid, 1);
        check("fetch_05", bus.fetch_instr, ref_mem[8'h05]);
        bus.fetch_addr = 8'hFF;
        @(posedge clk); #1;
        check("fetch_ff", bus.fetch_instr, ref_mem[8'hFF]);

        // Write while running is blocked.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 8'h30;
        bus.wr_data = 24'h123456;
        repeat (2) @(posedge clk);
        #1;
        check("blk_set", bus.wr_blocked, 1);
        bus.wr_req = 1'b0;
        bus.cpu_paused = 1'b1;
        @(posedge clk); #1;
        check("pause_owner", bus.owner, 0);
        check("blk_hold", bus.wr_blocked, 1);
        check("blk_we", we_cnt, 0);
        check("blk_ack", ack_cnt, 0);
        check("blk_mem", mem[8'h30], ref_mem[8'h30]);

        // Write then read back, plus boundary addresses.
        do_write(8'h10, 24'hABCDEF);
        check("wr_we_cnt", we_cnt, 1);
        check("wr_ack_cnt", ack_cnt, 1);
        do_read(8'h10);
        do_read(8'h00);
        do_read(8'hFF);

        // Tie: write, debug, write.
        exp_q.push_back(ref_mem[8'h41]);
        grants.delete();
        bus.wr_req      = 1'b1;
        bus.wr_addr     = 8'h40;
        bus.wr_data     = 24'h0F0F0F;
        bus.dbg_rd_req  = 1'b1;
        bus.dbg_rd_addr = 8'h41;
        n = 0;
        while (grants.size() < 3 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.wr_req     = 1'b0;
        bus.dbg_rd_req = 1'b0;
        ref_mem[8'h40] = 24'h0F0F0F;
        check("tie_cnt", grants.size(), 3);
        if (grants.size() >= 3) begin
            check("tie_g0", grants[0], 2);
            check("tie_g1", grants[1], 3);
            check("tie_g2", grants[2], 2);
        end
        check("tie_we_cnt", we_cnt, 3);
        @(posedge clk); #1;
        do_read(8'h40);

        // Unpause while a read is in flight.
        bus.fetch_addr  = 8'h10;
        exp_q.push_back(ref_mem[8'h80]);
        rv0 = rv_cnt;
        bus.dbg_rd_req  = 1'b1;
        bus.dbg_rd_addr = 8'h80;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.owner != 2'd3 && n < 10);
        check("up_read", bus.owner, 3);
        bus.cpu_paused = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.dbg_rd_valid)
                check("up_fv_rd", bus.fetch_valid, 0);
        end while (!bus.dbg_rd_valid && n < 10);
        check("up_rv_lat", n, 2);
        @(posedge clk); #1;
        bus.dbg_rd_req = 1'b0;
        check("up_hold_own", bus.owner, 0);
        check("up_hold_fv", bus.fetch_valid, 0);
        @(posedge clk); #1;
        check("up_idle_own", bus.owner, 0);
        check("up_idle_fv", bus.fetch_valid, 0);
        @(posedge clk); #1;
        check("up_run_own", bus.owner, 1);
        check("up_run_fv", bus.fetch_valid, 0);
        @(posedge clk); #1;
        check("up_fv", bus.fetch_valid, 1);
        check("up_instr", bus.fetch_instr, 24'hABCDEF);
        check("up_rv_cnt", rv_cnt - rv0, 1);

        // Async reset in the middle of a write.
        bus.cpu_paused = 1'b1;
        @(posedge clk); #1;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 8'h55;
        bus.wr_data = 24'h000001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.owner != 2'd2 && n < 10);
        check("ar_write", bus.owner, 2);
        rst = 1'b1;
        #1;
        check("ar_owner", bus.owner, 0);
        check("ar_ack", bus.wr_ack, 0);
        check("ar_we", bus.ram_we, 0);
        check("ar_en", bus.ram_en, 0);
        check("ar_blk", bus.wr_blocked, 0);
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ar_idle", bus.owner, 0);
        check("q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
